// File: rtl/alu_instruction_encoder.sv
// alu_instruction_encoder: packs ALU micro-op descriptors into 32-bit words and queues them in a FIFO
module alu_instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_const_c,
  input  logic [2:0]               in_alu_op,
  input  logic                     in_alu_form,
  input  logic [1:0]               in_vec_perci,
  input  logic [3:0]               in_a_sel,
  input  logic [3:0]               in_b_sel,
  input  logic [3:0]               in_c_sel,
  input  logic [3:0]               in_d_sel,
  input  logic [17:0]              in_constant,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     err_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         accepted_count,
  output logic [CNT_W-1:0]         err_count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, illegal, in_fire, push, pop;
  logic [31:0] word;
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign fifo_count = wr_ptr - rd_ptr;
  assign out_instr  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
  assign illegal    = in_const_c & in_alu_form;
  // a descriptor arriving during flush is consumed but neither queued nor counted
  assign in_fire    = in_valid & in_ready & !flush;
  assign push       = in_fire & !illegal;
  assign pop        = out_valid & out_ready & !flush;
  assign word = {3'b000, in_const_c, in_alu_op, in_alu_form, in_vec_perci,
                 in_const_c ? in_constant[17:12] : 6'h00, in_a_sel,
                 in_const_c ? in_constant[11:0] : {in_b_sel, in_c_sel, in_d_sel}};
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_pulse      <= 1'b0;
      accepted_count <= '0;
      err_count      <= '0;
    end else begin
      err_pulse <= in_fire & illegal;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
        if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (push) accepted_count <= accepted_count + CNT_W'(1);
      if (in_fire && illegal && !(&err_count)) err_count <= err_count + CNT_W'(1);
    end
endmodule

// File: doc/alu_instruction_encoder.md
Name: alu_instruction_encoder

Overview:
- Converts an ALU micro-op descriptor into the 32-bit ALU instruction word that the control path decodes.
- Sits between the program/microcode sequencer and the instruction-memory writer.
- Accepts descriptors on a valid/ready handshake, checks field legality, packs the word and buffers it in a small FIFO toward the writer.
- Rejects illegal field combinations and counts them.

Parameters:
- DEPTH, 4, number of output FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the accepted and error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  descriptor present.
- in_ready  out  1  encoder can take a descriptor.
- in_const_c  in  1  constant-form select.
- in_alu_op  in  3  ALU opcode.
- in_alu_form  in  1  instruction form.
- in_vec_perci  in  2  vector/carry mode.
- in_a_sel  in  4  operand A / Y1 register.
- in_b_sel  in  4  operand B register.
- in_c_sel  in  4  operand C / Y2 register.
- in_d_sel  in  4  operand D register.
- in_constant  in  18  immediate, used only in constant form.
- flush  in  1  synchronous FIFO clear.
- out_valid  out  1  instruction word available.
- out_ready  in  1  writer takes the word.
- out_instr  out  32  head-of-FIFO instruction word.
- err_pulse  out  1  one-cycle pulse on each rejected descriptor.
- fifo_count  out  log2(DEPTH)+1  current occupancy.
- accepted_count  out  CNT_W  descriptors enqueued, wrapping.
- err_count  out  CNT_W  descriptors rejected, saturating.

Behaviour:
- Reset (asynchronous, rst high):
  - FIFO empty: out_valid=0, fifo_count=0, out_instr=0.
  - err_pulse=0, accepted_count=0, err_count=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-transfer discards all buffered words; no partial word is ever emitted.
- Handshake rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !full. There is no pass-through when full, even if a pop happens in the same cycle.
  - out_valid = !empty. out_instr is held stable while out_valid & !out_ready.
- Legality check, on the transfer cycle:
  - in_const_c & in_alu_form is illegal.
  - An illegal descriptor is consumed (ready still high) but not enqueued.
  - It raises err_pulse for one cycle, registered (the cycle after the transfer).
  - It increments err_count, which saturates at all-ones.
- Packing of legal descriptors; all unlisted bits are 0:
  - [31:29] = 0.
  - [28] = const_c.
  - [27:25] = alu_op.
  - [24] = alu_form.
  - [23:22] = vec_perci.
  - Register form (const_c=0):
    - [21:16] = 0.
    - [15:12] = a_sel, [11:8] = b_sel, [7:4] = c_sel, [3:0] = d_sel.
  - Constant form (const_c=1, alu_form=0):
    - [21:16] = constant[17:12].
    - [15:12] = a_sel.
    - [11:0] = constant[11:0]; b_sel, c_sel and d_sel are ignored.
  - Each legal enqueue increments accepted_count, wrapping modulo 2^CNT_W.
- Latency: a word enqueued at edge N is visible on out_instr with out_valid=1 after edge N when the FIFO was empty (one cycle, registered storage).
- FIFO behaviour:
  - Circular, with read/write pointers one bit wider than the address.
  - Order is strict FIFO.
  - Full and empty are decoded from the pointers.
  - Wrap-around of both pointers must preserve order and occupancy.
- Simultaneous events:
  - Push and pop in the same cycle, not full: count unchanged, both pointers advance.
  - Push and pop at empty: the word is enqueued; the pop does not occur because out_valid was 0.
- Flush:
  - Clears the pointers and fifo_count on the next edge.
  - Flush takes priority over a push or pop in the same cycle.
  - A descriptor presented in the flush cycle is dropped and not counted.
  - The counters themselves are not cleared by flush.
- Illegal and legal descriptors never occur in the same cycle (one input port), so no arbitration is needed.

Test Plan:
- Register form: op=001, form=0, vec=00, a/b/c/d=1/2/3/4 -> out_instr=0x0200_1234 one cycle later; accepted_count=1.
- Constant form: const_c=1, op=000, form=0, vec=00, a=5, constant=0x3F123 -> out_instr=0x103F_5123.
- Illegal: const_c=1, form=1 -> err_pulse=1 for one cycle; err_count=1; fifo_count stays 0; out_valid stays 0.
- Full/backpressure and wrap-around:
  - With out_ready=0, push 4 words -> in_ready=0, fifo_count=4.
  - The 5th descriptor is not accepted.
  - Raise out_ready and drain -> words emerge in order.
  - Repeat 3 times -> no order corruption across pointer wrap.
- Simultaneous push/pop at count=2 -> count stays 2.
- Form=1, op=111, vec=11, a/b/c/d=F/E/D/C -> out_instr=0x0FC0_FEDC.
- Reset mid-drain with 3 words buffered -> out_valid=0 and fifo_count=0 immediately (asynchronously); counters read 0.
